// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - mnemonic-to-MIPS instruction encoder streaming into instruction memory
//
// Encodes mnemonic-level requests into 32-bit MIPS words.
// Buffers the words in a DEPTH-entry FIFO, tagged with sequential byte addresses,
// and drains them through a stallable instruction-memory write port.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i / req_ready_o    request handshake
//   mnem_i                       mnemonic code (0-12 legal, 13-15 illegal)
//   rs_i rt_i rd_i shamt_i       register / shift fields
//   funct_i imm_i target_i       function, immediate and jump target fields
//   imem_we_o / imem_ready_i     memory write handshake
//   imem_addr_o / imem_data_o    byte address and encoded word at the FIFO head
//   err_o                        one-cycle pulse after an illegal mnemonic is accepted
//   full_o                       program region exhausted (sticky until reset)
//   words_o                      number of words written to memory
module instr_encoder #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_WORDS = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  mnem_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [5:0]  funct_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic        imem_we_o,
    input  logic        imem_ready_i,
    output logic [31:0] imem_addr_o,
    output logic [31:0] imem_data_o,
    output logic        err_o,
    output logic        full_o,
    output logic [7:0]  words_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int AW = $clog2(MEM_WORDS + 1);
    localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
    localparam logic [AW-1:0] MEM_WORDS_C = AW'(MEM_WORDS);

    logic [31:0]   dataMem [DEPTH];
    logic [31:0]   addrMem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [CW-1:0] fifoCount;
    logic [31:0]   allocAddr;
    logic [AW-1:0] allocCnt;
    logic [31:0]   lastAddr;
    logic [31:0]   lastData;
    logic          errQ;
    logic [7:0]    wordCnt;

    logic          legal;
    logic [31:0]   encWord;
    logic          fifoEmpty;
    logic          accept;
    logic          push;
    logic          pop;

    always_comb begin
        legal   = 1'b1;
        encWord = '0;
        case (mnem_i)
            4'd0:    encWord = {6'b000000, rs_i, rt_i, rd_i, shamt_i, funct_i};
            4'd1:    encWord = {6'b001000, rs_i, rt_i, imm_i};
            4'd2:    encWord = {6'b001011, rs_i, rt_i, imm_i};
            4'd3:    encWord = {6'b000100, rs_i, rt_i, imm_i};
            4'd4:    encWord = {6'b001111, 5'd0, rt_i, imm_i};   // lui has no source register
            4'd5:    encWord = {6'b001101, rs_i, rt_i, imm_i};
            4'd6:    encWord = {6'b000101, rs_i, rt_i, imm_i};
            4'd7:    encWord = {6'b100011, rs_i, rt_i, imm_i};
            4'd8:    encWord = {6'b101011, rs_i, rt_i, imm_i};
            4'd9:    encWord = {6'b000010, target_i};
            4'd10:   encWord = {6'b000011, target_i};
            4'd11:   encWord = {6'b000110, rs_i, rt_i, imm_i};
            4'd12:   encWord = {6'b000001, rs_i, 5'd0, imm_i};   // REGIMM: rt=0 selects bltz
            default: legal   = 1'b0;
        endcase
    end

    assign fifoEmpty   = (fifoCount == '0);
    assign full_o      = (allocCnt == MEM_WORDS_C);
    // Ready looks only at state; a pop in the same cycle never frees a slot early.
    assign req_ready_o = (fifoCount < DEPTH_C) && !full_o;
    assign accept      = req_valid_i && req_ready_o;
    assign push        = accept && legal;
    assign pop         = !fifoEmpty && imem_ready_i;

    assign imem_we_o   = !fifoEmpty;
    // When the FIFO is empty the port keeps showing the last word written.
    assign imem_addr_o = fifoEmpty ? lastAddr : addrMem[rdPtr];
    assign imem_data_o = fifoEmpty ? lastData : dataMem[rdPtr];
    assign err_o       = errQ;
    assign words_o     = wordCnt;

    always_ff @(posedge clk_i) begin
        if (push) begin
            dataMem[wrPtr] <= encWord;
            addrMem[wrPtr] <= allocAddr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            fifoCount <= '0;
            allocAddr <= BASE_ADDR;
            allocCnt  <= '0;
            lastAddr  <= '0;
            lastData  <= '0;
            errQ      <= 1'b0;
            wordCnt   <= '0;
        end else begin
            errQ <= accept && !legal;
            if (push) begin
                wrPtr     <= wrPtr + PW'(1);
                allocAddr <= allocAddr + 32'd4;
                allocCnt  <= allocCnt + AW'(1);
            end
            if (pop) begin
                rdPtr    <= rdPtr + PW'(1);
                lastAddr <= addrMem[rdPtr];
                lastData <= dataMem[rdPtr];
                wordCnt  <= wordCnt + 8'd1;
            end
            case ({push, pop})
                2'b10:   fifoCount <= fifoCount + CW'(1);
                2'b01:   fifoCount <= fifoCount - CW'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int MW1   = 128;
    localparam logic [5:0] OP_TAB [13] = '{6'd0, 6'd8, 6'd11, 6'd4, 6'd15, 6'd13, 6'd5, 6'd35, 6'd43, 6'd2, 6'd3, 6'd6, 6'd1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        reqValid = 1'b0, reqValid2 = 1'b0;
    logic        imemReady = 1'b1, imemReady2 = 1'b0;
    logic [3:0]  mnem = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm = '0;
    logic [25:0] target = '0;

    logic        reqReady, we, err, full;
    logic [31:0] addr, data;
    logic [7:0]  words;
    logic        reqReady2, we2, err2, full2;
    logic [31:0] addr2, data2;
    logic [7:0]  words2;

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .MEM_WORDS(MW1)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(reqValid), .req_ready_o(reqReady),
        .mnem_i(mnem), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct),
        .imm_i(imm), .target_i(target), .imem_we_o(we), .imem_ready_i(imemReady),
        .imem_addr_o(addr), .imem_data_o(data), .err_o(err), .full_o(full), .words_o(words)
    );

    instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0), .MEM_WORDS(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(reqValid2), .req_ready_o(reqReady2),
        .mnem_i(mnem), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct),
        .imm_i(imm), .target_i(target), .imem_we_o(we2), .imem_ready_i(imemReady2),
        .imem_addr_o(addr2), .imem_data_o(data2), .err_o(err2), .full_o(full2), .words_o(words2)
    );

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder built from the opcode table and field layout.
    function automatic logic [31:0] refEnc(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t,
                                           input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                                           input logic [15:0] im, input logic [25:0] tg);
        logic [31:0] op;
        op = 32'(OP_TAB[m]) << 26;
        if (m == 4'd0) return op | (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | (32'(sh) << 6) | 32'(fn);
        if (m == 4'd9 || m == 4'd10) return op | 32'(tg);
        if (m == 4'd4) s = 5'd0;
        if (m == 4'd12) t = 5'd0;
        return op | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
    endfunction

    // Scoreboard model of the default instance.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         q[$];
    logic [31:0] mAlloc, mLastAddr, mLastData;
    int          mCnt;
    logic [7:0]  mWords;
    logic        mErr;
    bit          modelOn = 1'b0;

    always @(negedge clk) begin
        bit  rdy;
        wr_t e;
        rdy = (q.size() < DEPTH) && (mCnt < MW1);
        if (modelOn) begin
            check("mon_ready", 32'(reqReady), 32'(rdy));
            check("mon_we", 32'(we), 32'(q.size() != 0));
            check("mon_err", 32'(err), 32'(mErr));
            check("mon_full", 32'(full), 32'(mCnt == MW1));
            check("mon_words", 32'(words), 32'(mWords));
            if (q.size() != 0) begin
                check("mon_addr", addr, q[0].addr);
                check("mon_data", data, q[0].data);
            end else begin
                check("mon_hold_addr", addr, mLastAddr);
                check("mon_hold_data", data, mLastData);
            end
        end
        if (rst) begin
            q.delete();
            mAlloc = 32'h0; mLastAddr = '0; mLastData = '0;
            mCnt = 0; mWords = '0; mErr = 1'b0;
            modelOn = 1'b1;
        end else if (modelOn) begin
            mErr = 1'b0;
            if (q.size() != 0 && imemReady) begin
                mLastAddr = q[0].addr;
                mLastData = q[0].data;
                void'(q.pop_front());
                mWords++;
            end
            if (reqValid && rdy) begin
                if (mnem <= 4'd12) begin
                    e.addr = mAlloc;
                    e.data = refEnc(mnem, rs, rt, rd, shamt, funct, imm, target);
                    q.push_back(e);
                    mAlloc += 32'd4;
                    mCnt++;
                end else begin
                    mErr = 1'b1;
                end
            end
        end
    end

    task automatic setFields(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                             input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
        mnem = m; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm = im; target = tg;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst = 1'b1; reqValid = 1'b0; reqValid2 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Presents one request on the default instance and waits for its acceptance edge.
    task automatic pushReq(input logic [3:0] m, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                           input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] im, input logic [25:0] tg);
        bit done;
        done = 1'b0;
        @(posedge clk); #1;
        setFields(m, s, t, d, sh, fn, im, tg);
        reqValid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = reqReady;
            @(posedge clk); #1;
        end
        reqValid = 1'b0;
        if (!done) begin
            nChecks++; nFails++;
            $display("FAIL push_timeout: request mnem=%0d never accepted", m);
        end
    endtask

    typedef struct {
        logic [3:0]  m;
        logic [4:0]  s, t, d, sh;
        logic [5:0]  fn;
        logic [15:0] im;
        logic [25:0] tg;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit acc;
        vecs[0] = '{4'd1,  5'd0,  5'd8,  5'd0,  5'd0, 6'd0,  16'd5,      26'd0,        32'h20080005};
        vecs[1] = '{4'd0,  5'd8,  5'd9,  5'd10, 5'd0, 6'h20, 16'd0,      26'd0,        32'h01095020};
        vecs[2] = '{4'd9,  5'd0,  5'd0,  5'd0,  5'd0, 6'd0,  16'd0,      26'h10,       32'h08000010};
        vecs[3] = '{4'd4,  5'd3,  5'd1,  5'd0,  5'd0, 6'd0,  16'h1234,   26'd0,        32'h3C011234};
        vecs[4] = '{4'd12, 5'd4,  5'd7,  5'd0,  5'd0, 6'd0,  16'hFFFE,   26'd0,        32'h0480FFFE};
        vecs[5] = '{4'd10, 5'd1,  5'd2,  5'd3,  5'd4, 6'd5,  16'h1111,   26'h3FFFFFF,  32'h0FFFFFFF};
        vecs[6] = '{4'd8,  5'd29, 5'd31, 5'd0,  5'd0, 6'd0,  16'h8000,   26'd0,        32'hAFBF8000};
        vecs[7] = '{4'd11, 5'd1,  5'd2,  5'd0,  5'd0, 6'd0,  16'hFFFF,   26'd0,        32'h1822FFFF};
        vecs[8] = '{4'd0,  5'd0,  5'd9,  5'd10, 5'd3, 6'd0,  16'd0,      26'd0,        32'h000950C0};

        // Reset state
        doReset();
        @(negedge clk);
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_words", 32'(words), 32'd0);
        check("rst_ready", 32'(reqReady), 32'd1);

        // Encoding table, memory always ready
        imemReady = 1'b1;
        for (int i = 0; i < 9; i++) begin
            pushReq(vecs[i].m, vecs[i].s, vecs[i].t, vecs[i].d, vecs[i].sh, vecs[i].fn, vecs[i].im, vecs[i].tg);
            @(negedge clk);
            check("vec_we", 32'(we), 32'd1);
            check("vec_data", data, vecs[i].exp);
            check("vec_addr", addr, 32'(4 * i));
            @(negedge clk);
            check("vec_words", 32'(words), 32'(i + 1));
        end

        // Backpressure: four accepts fill the FIFO, the fifth waits
        doReset();
        imemReady = 1'b0;
        for (int i = 0; i < 4; i++) pushReq(4'd5, 5'd0, 5'(i + 1), 5'd0, 5'd0, 6'd0, 16'(i), 26'd0);
        setFields(4'd5, 5'd0, 5'd5, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0);
        reqValid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("bp_ready_low", 32'(reqReady), 32'd0);
            check("bp_head_addr", addr, 32'h0);
            check("bp_head_data", data, 32'h34010000);
            @(posedge clk); #1;
        end
        imemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_drain_we", 32'(we), 32'd1);
            check("bp_drain_addr", addr, 32'(4 * i));
            acc = reqValid && reqReady;
            @(posedge clk); #1;
            if (acc) reqValid = 1'b0;
        end
        check("bp_fifth_accepted", 32'(reqValid), 32'd0);
        @(negedge clk);
        check("bp_empty", 32'(we), 32'd0);

        // Illegal mnemonic
        doReset();
        pushReq(4'd14, 5'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h55, 26'd0);
        @(negedge clk);
        check("ill_err_pulse", 32'(err), 32'd1);
        check("ill_no_write", 32'(we), 32'd0);
        @(negedge clk);
        check("ill_err_clear", 32'(err), 32'd0);
        pushReq(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0);
        @(negedge clk);
        check("ill_next_addr", addr, 32'h0);
        check("ill_next_data", data, 32'h20080005);

        // Region exhaustion on the MEM_WORDS=2 instance, then reset mid-drain
        doReset();
        setFields(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0);
        imemReady2 = 1'b0;
        reqValid2  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("fw_ready", 32'(reqReady2), 32'd1);
            check("fw_full_low", 32'(full2), 32'd0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fw_full", 32'(full2), 32'd1);
            check("fw_third_blocked", 32'(reqReady2), 32'd0);
            check("fw_head_addr", addr2, 32'h0);
            @(posedge clk); #1;
        end
        reqValid2  = 1'b0;
        imemReady2 = 1'b1;
        @(negedge clk);
        check("fw_we", 32'(we2), 32'd1);
        @(posedge clk); #1;
        imemReady2 = 1'b0;
        @(negedge clk);
        check("fw_words", 32'(words2), 32'd1);
        check("fw_second_addr", addr2, 32'h4);
        check("fw_still_full", 32'(full2), 32'd1);
        doReset();
        @(negedge clk);
        check("fw_rst_we", 32'(we2), 32'd0);
        check("fw_rst_words", 32'(words2), 32'd0);
        check("fw_rst_full", 32'(full2), 32'd0);
        check("fw_rst_ready", 32'(reqReady2), 32'd1);
        @(posedge clk); #1;
        setFields(4'd7, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h10, 26'd0);
        reqValid2 = 1'b1;
        @(posedge clk); #1;
        reqValid2 = 1'b0;
        @(negedge clk);
        check("fw_base_we", 32'(we2), 32'd1);
        check("fw_base_addr", addr2, 32'h0);
        check("fw_base_data", data2, 32'h8C430010);

        // Randomized traffic against the scoreboard, long enough to exhaust the region
        doReset();
        for (int c = 0; c < 500; c++) begin
            @(posedge clk); #1;
            reqValid  = ($urandom_range(0, 99) < 60);
            imemReady = ($urandom_range(0, 99) < 50);
            setFields(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                      6'($urandom), 16'($urandom), 26'($urandom));
        end
        @(posedge clk); #1;
        reqValid  = 1'b0;
        imemReady = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rnd_drained", 32'(we), 32'd0);
        check("rnd_words", 32'(words), 32'(mWords));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Writer-side counterpart of the CPU's opcode decoder: accepts mnemonic-level instruction requests and encodes each into a 32-bit MIPS word, using the same opcode map the decoder consumes.
- Buffers encoded words in a small FIFO and streams them into instruction memory through a stallable write port, at sequential word addresses.
- Used by test harnesses and the boot loader to build programs in instruction memory.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2).
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.
- MEM_WORDS, 128, capacity of the program region in words.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request can be accepted this cycle.
- mnem_i  input  4  0 R-type, 1 addi, 2 sltiu, 3 beq, 4 lui, 5 ori, 6 bne, 7 lw, 8 sw, 9 j, 10 jal, 11 ble, 12 bltz; 13-15 are illegal.
- rs_i, rt_i, rd_i  input  5 each  register fields.
- shamt_i  input  5  shift amount (R-type only).
- funct_i  input  6  function field (R-type only).
- imm_i  input  16  immediate or branch offset.
- target_i  input  26  jump target field.
- imem_we_o  output  1  write request (FIFO non-empty).
- imem_ready_i  input  1  memory accepts the write this cycle.
- imem_addr_o  output  32  byte address of the head word.
- imem_data_o  output  32  encoded head word.
- err_o  output  1  one-cycle pulse when an illegal mnemonic is accepted.
- full_o  output  1  program region exhausted.
- words_o  output  8  count of words actually written to memory.

Behaviour:
- **Reset** (synchronous, `rst_i` = 1 at an edge):
  - FIFO emptied; `alloc_addr` = BASE_ADDR; `alloc_cnt` = 0.
  - `imem_we_o` = 0, `imem_addr_o` = 0, `imem_data_o` = 0, `err_o` = 0, `full_o` = 0, `words_o` = 0.
  - `req_ready_o` = 1 in the first cycle after reset.
  - Reset mid-operation discards all buffered words. Writes already completed in memory are not undone.
- **Acceptance**
  - `req_ready_o` = (fifo_count < DEPTH) && !full_o. It is combinational from state only and never depends on `req_valid_i`.
  - A request is accepted when `req_valid_i` && `req_ready_o`.
- **Encoding** (registered into the FIFO; opcodes in binary):
  - R-type: op 000000, then rs, rt, rd, shamt, funct.
  - I-type {op, rs, rt, imm}: addi 001000, sltiu 001011, beq 000100, ori 001101, bne 000101, lw 100011, sw 101011, ble 000110.
  - lui: op 001111, rs field forced to 0.
  - bltz: op 000001, rt field forced to 0.
  - j: op 000010; jal: op 000011; both formatted {op, target}.
  - Fields not used by a format are ignored.
- **Addressing**
  - Each legal accepted word is tagged with `alloc_addr`.
  - On acceptance: `alloc_addr` += 4 and `alloc_cnt` += 1.
  - `full_o` = 1 once `alloc_cnt` == MEM_WORDS. It stays set until reset; there is no wrap-around.
- **Illegal mnemonic**
  - Accepted (handshake completes) but not enqueued; no address is consumed.
  - `err_o` = 1 in the cycle after acceptance, for one cycle only.
- **Latency**: a word accepted at edge N appears on `imem_we_o`/`imem_addr_o`/`imem_data_o` from cycle N+1 if the FIFO was empty. There is no same-cycle bypass.
- **Drain**
  - A write completes at an edge where `imem_we_o` && `imem_ready_i`. The FIFO then pops and `words_o` += 1.
  - Head outputs hold stable while `imem_ready_i` = 0.
  - In-order, one word per cycle maximum.
- **Simultaneous push and pop**: the count is unchanged. When the FIFO is full, `req_ready_o` = 0 in that cycle regardless of a concurrent pop (no pass-through).
- **Empty FIFO**: `imem_we_o` = 0; address and data outputs hold their last values.

Test Plan:
- addi rs=0 rt=8 imm=5, `imem_ready_i`=1 → cycle N+1: `imem_we_o`=1, addr 0x00000000, data 0x20080005; `words_o`=1 after the edge.
- R-type rs=8 rt=9 rd=10 shamt=0 funct=0x20, then j target=0x10 → data 0x01095020 @0x0, then 0x08000010 @0x4.
- lui rs_i=3 rt=1 imm=0x1234 → 0x3C011234; bltz rs=4 rt_i=7 imm=0xFFFE → 0x0480FFFE (forced fields zeroed).
- `imem_ready_i`=0, push 5 valid requests back-to-back:
  - → `req_ready_o` drops after 4 accepts; head holds 0x0 address/data.
  - Release → 4 writes on consecutive cycles at addresses 0x0, 0x4, 0x8, 0xC; the 5th request is then accepted at 0x10.
- mnem_i=14 accepted → `err_o` pulse of 1 cycle, no write. The next legal word gets address 0x0.
- MEM_WORDS=2: three requests → `full_o`=1 after the 2nd accept; the 3rd is never accepted. Assert `rst_i` mid-drain → FIFO empty, `words_o`=0, next word at BASE_ADDR.
